i2s_tx_10xe_axi4_lite_regs: RTL and testbench

AXI4-Lite slave control/status register file for the I2S transmitter. It sits directly downstream of the AXI4-Lite control interface and terminates all five channels. It decodes 8-bit word addresses and drives the static control fields (enable, mute, SCLK divider, channel mux) into the I2S TX datapath. It also latches datapath event pulses into a maskable interrupt.

---
 rtl/i2s_tx_10xe_axi4_lite_regs_pkg.sv | 26 ++
 rtl/i2s_tx_10xe_axi4_lite_regs_if.sv | 29 ++
 rtl/i2s_tx_10xe_axi4_lite_regs.sv | 155 +++++++++++++++
 tb/tb_i2s_tx_10xe_axi4_lite_regs.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tx_10xe_axi4_lite_regs_pkg.sv
// Shared definitions for the I2S TX control/status register file:
// the word address map, AXI response codes, FSM encodings and the control bundle.
package i2s_tx_10xe_regs_pkg;

   localparam logic [7:0] ADDR_VERSION  = 8'h00;
   localparam logic [7:0] ADDR_CONFIG   = 8'h04;
   localparam logic [7:0] ADDR_CTRL     = 8'h08;
   localparam logic [7:0] ADDR_IRQ_EN   = 8'h10;
   localparam logic [7:0] ADDR_IRQ_STS  = 8'h14;
   localparam logic [7:0] ADDR_SCLK_DIV = 8'h20;
   localparam logic [7:0] ADDR_CH_MUX   = 8'h30;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_DATA} rd_state_e;

   typedef struct packed {
      logic       enable;
      logic       mute;
      logic [7:0] sclk_div;
      logic [2:0] ch_mux;
   } ctrl_regs_t;

endpackage

// File: rtl/i2s_tx_10xe_axi4_lite_regs_if.sv
// AXI4-Lite control bus (8-bit address, 32-bit data, no strobes).
interface i2s_tx_10xe_axi4_lite_regs_if;
   logic        awvalid;
   logic        awready;
   logic [7:0]  awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [7:0]  araddr;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/i2s_tx_10xe_axi4_lite_regs.sv
// AXI4-Lite register file for the I2S transmitter: static control fields plus
// a sticky, maskable event interrupt.
//
// state  | meaning
// W_IDLE | waiting for AW and W together; both accepted on the same edge
// W_RESP | write done, bvalid held until bready
// R_IDLE | arready high, waiting for arvalid
// R_DATA | rdata/rresp captured, rvalid held until rready
module i2s_tx_10xe_axi4_lite_regs
   import i2s_tx_10xe_regs_pkg::*;
#(
   parameter logic [31:0] VERSION      = 32'h0001_0000,
   parameter int          DATA_WIDTH   = 24,
   parameter int          NUM_CH_PAIRS = 1
) (
   input  logic                       s_axi_ctrl_aclk,
   input  logic                       s_axi_ctrl_aresetn,
   i2s_tx_10xe_axi4_lite_regs_if.slave s_axi_ctrl,
   input  logic                       evt_underflow,
   input  logic                       evt_blk_done,
   output logic                       ctrl_enable,
   output logic                       ctrl_mute,
   output logic [7:0]                 sclk_div,
   output logic [2:0]                 ch_mux,
   output logic                       irq
);

   localparam logic [31:0] CONFIG_VAL = {21'd0, 3'(NUM_CH_PAIRS), 2'b00, 6'(DATA_WIDTH)};

   wr_state_e  wr_state, wr_state_nxt;
   rd_state_e  rd_state, rd_state_nxt;
   ctrl_regs_t ctrl_q;
   logic [1:0] irq_en_q, irq_sts_q, sts_clr;
   logic       irq_q;
   logic [1:0] bresp_q, rresp_q;
   logic [31:0] rdata_q, rd_val;
   logic       wr_hs, rd_hs, wr_ok, rd_ok;
   logic [7:0] wr_word, rd_word;
   logic       unused_bits;

   assign wr_word = {s_axi_ctrl.awaddr[7:2], 2'b00};
   assign rd_word = {s_axi_ctrl.araddr[7:2], 2'b00};
   assign unused_bits = ^{s_axi_ctrl.wdata[31:8], s_axi_ctrl.awaddr[1:0], s_axi_ctrl.araddr[1:0]};

   always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
      if (!s_axi_ctrl_aresetn) begin
         wr_state <= W_IDLE;
         rd_state <= R_IDLE;
      end else begin
         wr_state <= wr_state_nxt;
         rd_state <= rd_state_nxt;
      end
   end

   // Ready terms are gated by reset so nothing handshakes while reset is held.
   always_comb begin
      wr_state_nxt = wr_state;
      wr_hs        = 1'b0;
      case (wr_state)
         W_IDLE: if (s_axi_ctrl.awvalid && s_axi_ctrl.wvalid && s_axi_ctrl_aresetn) begin
            wr_hs        = 1'b1;
            wr_state_nxt = W_RESP;
         end
         W_RESP: if (s_axi_ctrl.bready) wr_state_nxt = W_IDLE;
         default: wr_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_nxt = rd_state;
      rd_hs        = 1'b0;
      case (rd_state)
         R_IDLE: if (s_axi_ctrl.arvalid && s_axi_ctrl_aresetn) begin
            rd_hs        = 1'b1;
            rd_state_nxt = R_DATA;
         end
         R_DATA: if (s_axi_ctrl.rready) rd_state_nxt = R_IDLE;
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      wr_ok = 1'b0;
      case (wr_word)
         ADDR_CTRL, ADDR_IRQ_EN, ADDR_IRQ_STS, ADDR_SCLK_DIV, ADDR_CH_MUX: wr_ok = 1'b1;
         default: wr_ok = 1'b0;
      endcase
   end

   always_comb begin
      rd_val = 32'd0;
      rd_ok  = 1'b1;
      case (rd_word)
         ADDR_VERSION:  rd_val = VERSION;
         ADDR_CONFIG:   rd_val = CONFIG_VAL;
         ADDR_CTRL:     rd_val = {30'd0, ctrl_q.mute, ctrl_q.enable};
         ADDR_IRQ_EN:   rd_val = {30'd0, irq_en_q};
         ADDR_IRQ_STS:  rd_val = {30'd0, irq_sts_q};
         ADDR_SCLK_DIV: rd_val = {24'd0, ctrl_q.sclk_div};
         ADDR_CH_MUX:   rd_val = {29'd0, ctrl_q.ch_mux};
         default:       rd_ok  = 1'b0;
      endcase
   end

   assign sts_clr = (wr_hs && wr_word == ADDR_IRQ_STS) ? s_axi_ctrl.wdata[1:0] : 2'b00;

   always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
      if (!s_axi_ctrl_aresetn) begin
         ctrl_q    <= '0;
         irq_en_q  <= 2'b00;
         irq_sts_q <= 2'b00;
         irq_q     <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= 32'd0;
      end else begin
         if (wr_hs) begin
            bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            case (wr_word)
               ADDR_CTRL: begin
                  ctrl_q.enable <= s_axi_ctrl.wdata[0];
                  ctrl_q.mute   <= s_axi_ctrl.wdata[1];
               end
               ADDR_IRQ_EN:   irq_en_q        <= s_axi_ctrl.wdata[1:0];
               ADDR_SCLK_DIV: ctrl_q.sclk_div <= s_axi_ctrl.wdata[7:0];
               ADDR_CH_MUX:   ctrl_q.ch_mux   <= s_axi_ctrl.wdata[2:0];
               default: ;
            endcase
         end
         // Reads sample the pre-write register values on a shared edge.
         if (rd_hs) begin
            rdata_q <= rd_val;
            rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
         end
         irq_sts_q <= (irq_sts_q & ~sts_clr) | {evt_blk_done, evt_underflow};
         irq_q     <= |(irq_sts_q & irq_en_q);
      end
   end

   assign s_axi_ctrl.awready = wr_hs;
   assign s_axi_ctrl.wready  = wr_hs;
   assign s_axi_ctrl.bvalid  = (wr_state == W_RESP);
   assign s_axi_ctrl.bresp   = bresp_q;
   assign s_axi_ctrl.arready = (rd_state == R_IDLE) && s_axi_ctrl_aresetn;
   assign s_axi_ctrl.rvalid  = (rd_state == R_DATA);
   assign s_axi_ctrl.rdata   = rdata_q;
   assign s_axi_ctrl.rresp   = rresp_q;

   assign ctrl_enable = ctrl_q.enable;
   assign ctrl_mute   = ctrl_q.mute;
   assign sclk_div    = ctrl_q.sclk_div;
   assign ch_mux      = ctrl_q.ch_mux;
   assign irq         = irq_q;

endmodule

// File: tb/tb_i2s_tx_10xe_axi4_lite_regs.sv
// Scoreboard bench for the I2S TX register file: drivers push expected
// responses from a register-map model, a negedge monitor pops and compares.
module tb_i2s_tx_10xe_axi4_lite_regs;
   import i2s_tx_10xe_regs_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       evt_underflow = 1'b0, evt_blk_done = 1'b0;
   logic       ctrl_enable, ctrl_mute, irq;
   logic [7:0] sclk_div;
   logic [2:0] ch_mux;

   always #5 clk = ~clk;

   i2s_tx_10xe_axi4_lite_regs_if bus ();

   i2s_tx_10xe_axi4_lite_regs dut (
      .s_axi_ctrl_aclk    (clk),
      .s_axi_ctrl_aresetn (rst_n),
      .s_axi_ctrl         (bus.slave),
      .evt_underflow      (evt_underflow),
      .evt_blk_done       (evt_blk_done),
      .ctrl_enable        (ctrl_enable),
      .ctrl_mute          (ctrl_mute),
      .sclk_div           (sclk_div),
      .ch_mux             (ch_mux),
      .irq                (irq)
   );

   typedef struct packed {logic [31:0] d; logic [1:0] r;} rsp_t;

   int         checks = 0;
   int         errors = 0;
   logic [1:0] wq[$];
   rsp_t       rq[$];

   // Register-map model: field contents only, keyed by word address.
   logic [1:0] m_ctrl, m_en, m_sts;
   logic [7:0] m_div;
   logic [2:0] m_mux;

   task automatic model_reset();
      m_ctrl = 0; m_en = 0; m_sts = 0; m_div = 0; m_mux = 0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rsp_t model_read(input logic [7:0] a);
      rsp_t s;
      s.d = 32'd0;
      s.r = 2'b00;
      case (a & 8'hFC)
         8'h00:   s.d = 32'h0001_0000;
         8'h04:   s.d = 32'h0000_0118;
         8'h08:   s.d = {30'd0, m_ctrl};
         8'h10:   s.d = {30'd0, m_en};
         8'h14:   s.d = {30'd0, m_sts};
         8'h20:   s.d = {24'd0, m_div};
         8'h30:   s.d = {29'd0, m_mux};
         default: s.r = 2'b10;
      endcase
      return s;
   endfunction

   function automatic logic [1:0] model_wresp(input logic [7:0] a);
      case (a & 8'hFC)
         8'h08, 8'h10, 8'h14, 8'h20, 8'h30: return 2'b00;
         default: return 2'b10;
      endcase
   endfunction

   task automatic model_write(input logic [7:0] a, input logic [31:0] d);
      case (a & 8'hFC)
         8'h08: m_ctrl = d[1:0];
         8'h10: m_en   = d[1:0];
         8'h14: m_sts  = m_sts & ~d[1:0];
         8'h20: m_div  = d[7:0];
         8'h30: m_mux  = d[2:0];
         default: ;
      endcase
   endtask

   always @(negedge clk) begin : monitor
      logic [1:0] eb;
      rsp_t       er;
      if (rst_n && bus.bvalid && bus.bready) begin
         if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL bresp_unexpected: got response %h, expected none", bus.bresp);
         end else begin
            eb = wq.pop_front();
            check("bresp", 32'(bus.bresp), 32'(eb));
         end
      end
      if (rst_n && bus.rvalid && bus.rready) begin
         if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL rdata_unexpected: got %h, expected none", bus.rdata);
         end else begin
            er = rq.pop_front();
            check("rdata", bus.rdata, er.d);
            check("rresp", 32'(bus.rresp), 32'(er.r));
         end
      end
   end

   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                            input int aw_dly, input int w_dly, input int b_dly);
      int  need;
      bit  done;
      logic [1:0] er;
      need = (aw_dly > w_dly) ? aw_dly : w_dly;
      er   = model_wresp(a);
      wq.push_back(er);
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         bus.awvalid = (c >= aw_dly);
         bus.awaddr  = a;
         bus.wvalid  = (c >= w_dly);
         bus.wdata   = d;
         @(negedge clk);
         if (bus.awready && bus.wready) begin
            check("wr_accept_cycle", 32'(c), 32'(need));
            done = 1;
         end
         @(posedge clk); #1;
      end
      bus.awvalid = 0;
      bus.wvalid  = 0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL wr_timeout: got no handshake, expected one within 40 cycles");
         void'(wq.pop_back());
         return;
      end
      model_write(a, d);
      @(negedge clk);
      check("bvalid_latency", 32'(bus.bvalid), 32'd1);
      for (int i = 0; i < b_dly; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("bvalid_hold", 32'(bus.bvalid), 32'd1);
         check("bresp_hold", 32'(bus.bresp), 32'(er));
      end
      @(posedge clk); #1;
      bus.bready = 1;
      @(posedge clk); #1;
      bus.bready = 0;
      @(negedge clk);
      check("bvalid_clear", 32'(bus.bvalid), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [7:0] a, input int ar_dly, input int r_dly);
      bit   done;
      rsp_t er;
      er = model_read(a);
      rq.push_back(er);
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         bus.arvalid = (c >= ar_dly);
         bus.araddr  = a;
         @(negedge clk);
         if (bus.arvalid && bus.arready) begin
            check("rd_accept_cycle", 32'(c), 32'(ar_dly));
            done = 1;
         end
         @(posedge clk); #1;
      end
      bus.arvalid = 0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL rd_timeout: got no handshake, expected one within 40 cycles");
         void'(rq.pop_back());
         return;
      end
      @(negedge clk);
      check("rvalid_latency", 32'(bus.rvalid), 32'd1);
      for (int i = 0; i < r_dly; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("rvalid_hold", 32'(bus.rvalid), 32'd1);
         check("rdata_hold", bus.rdata, er.d);
      end
      @(posedge clk); #1;
      bus.rready = 1;
      @(posedge clk); #1;
      bus.rready = 0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_evt(input logic [1:0] sel);
      evt_underflow = sel[0];
      evt_blk_done  = sel[1];
      @(posedge clk); #1;
      evt_underflow = 0;
      evt_blk_done  = 0;
      m_sts = m_sts | sel;
   endtask

   task automatic check_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("ctrl_enable", 32'(ctrl_enable), 32'(m_ctrl[0]));
      check("ctrl_mute", 32'(ctrl_mute), 32'(m_ctrl[1]));
      check("sclk_div", 32'(sclk_div), 32'(m_div));
      check("ch_mux", 32'(ch_mux), 32'(m_mux));
      check("irq", 32'(irq), 32'(|(m_sts & m_en)));
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0] pool [10];
      logic [7:0] a;
      int         op;
      pool = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h20, 8'h30, 8'h0C, 8'h44, 8'hFC};
      bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.bready = 0;
      bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
      model_reset();

      #12;
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_arready", 32'(bus.arready), 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_sclk_div", 32'(sclk_div), 32'd0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      foreach (pool[i]) if (i < 7) axi_read(pool[i], 0, 0);

      axi_write(8'h20, 32'hFFFF_FF3C, 0, 0, 0);
      axi_read(8'h20, 0, 1);
      check_outputs();

      axi_write(8'h30, 32'h0000_0005, 0, 3, 5);
      axi_write(8'h08, 32'h0000_0002, 2, 0, 1);
      check_outputs();

      // Same-edge read and write of one register: read sees the old value.
      fork
         axi_write(8'h20, 32'h0000_0055, 0, 0, 1);
         axi_read(8'h20, 0, 0);
      join
      check_outputs();

      axi_write(8'h10, 32'h3, 0, 0, 0);
      pulse_evt(2'b01);
      @(negedge clk);
      check("irq_one_cycle_late", 32'(irq), 32'd0);
      @(negedge clk);
      check("irq_set", 32'(irq), 32'd1);
      @(posedge clk); #1;
      axi_read(8'h14, 0, 0);
      fork
         axi_write(8'h14, 32'h1, 0, 0, 0);
         pulse_evt(2'b01);
      join
      m_sts[0] = 1'b1;  // set beats clear on a shared edge
      axi_read(8'h14, 0, 0);
      check_outputs();
      axi_write(8'h14, 32'h1, 0, 0, 0);
      check_outputs();

      axi_write(8'h00, 32'hDEAD_BEEF, 0, 0, 0);
      axi_read(8'h00, 0, 0);
      axi_read(8'h44, 0, 2);

      for (int n = 0; n < 120; n++) begin
         op = $urandom_range(0, 9);
         a  = pool[$urandom_range(0, 9)] | 8'($urandom_range(0, 3));
         if (op < 4)
            axi_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else if (op < 8)
            axi_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
         else
            pulse_evt(2'($urandom_range(1, 3)));
         check_outputs();
      end

      axi_write(8'h08, 32'h3, 0, 0, 0);
      check_outputs();
      bus.arvalid = 1; bus.araddr = 8'h08;
      @(posedge clk); #1;
      bus.arvalid = 0;
      @(negedge clk);
      check("rvalid_before_reset", 32'(bus.rvalid), 32'd1);
      #2 rst_n = 0;
      #1;
      check("async_rst_enable", 32'(ctrl_enable), 32'd0);
      check("async_rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("async_rst_arready", 32'(bus.arready), 32'd0);
      check("async_rst_irq", 32'(irq), 32'd0);
      model_reset();
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      axi_read(8'h08, 0, 0);
      check_outputs();

      repeat (3) @(posedge clk);
      if (wq.size() != 0 || rq.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", wq.size(), rq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
